key_schedule_unit: RTL

Sequential AES-128 key schedule controller placed directly upstream of the round key-expansion stage. It accepts a 128-bit cipher key through a valid/ready handshake and iterates the combinational round key-expansion block once per cycle with rc = 1..NR. It stores all NR+1 round keys in an internal table and serves them to the cipher core through a registered read port.

---
 rtl/aes_key_pkg.sv | 65 ++++++
 rtl/key_schedule_unit_keygen.sv | 26 ++
 rtl/key_schedule_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule types, constants and GF(2^8) helpers.
// Also holds the FIPS-197 key-expansion vectors used by the bench.
package aes_key_pkg;

  localparam int NR_DEF = 10;
  localparam int KEY_W  = 128;
  localparam int RC_W   = 4;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} ks_state_e;

  typedef logic [KEY_W-1:0] round_key_t;

  localparam round_key_t FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam round_key_t FIPS_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam round_key_t FIPS_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam round_key_t APPB_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam round_key_t APPB_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_schedule_unit_keygen.sv
// Combinational AES-128 round key expansion: new_key = expand(rc, key).
module KeyGenerator
  import aes_key_pkg::*;
(
  input  logic [RC_W-1:0] rc,
  input  round_key_t      key,
  output round_key_t      new_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    {w0, w1, w2, w3} = key;
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon(rc), 24'h000000};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    new_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/key_schedule_unit.sv
// Sequential AES-128 key schedule: expands one round key per cycle into a table
// served through a registered read port. KEY_SCHED_INV_EN adds reverse addressing (rk_inv).
module key_schedule_unit
  import aes_key_pkg::*;
#(
  parameter int NR     = NR_DEF,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              table_valid,
  input  logic [ADDR_W-1:0] rk_addr,
`ifdef KEY_SCHED_INV_EN
  input  logic              rk_inv,
`endif
  output logic [KEY_W-1:0]  rk_data
);

  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(NR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NR);

  ks_state_e         state, state_nx;
  logic [RC_W-1:0]   rc;
  round_key_t        work_key;
  round_key_t        next_key;
  round_key_t        tbl [0:NR];
  logic              accept;
  logic [ADDR_W-1:0] eff_addr;
  round_key_t        rd_word;

  KeyGenerator u_keygen (
    .rc      (rc),
    .key     (work_key),
    .new_key (next_key)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE, READY: begin
        if (key_valid && !clear) begin
          accept   = 1'b1;
          state_nx = EXPAND;
        end
      end
      EXPAND: if (rc == RC_LAST) state_nx = READY;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);

  always_comb begin
`ifdef KEY_SCHED_INV_EN
    eff_addr = rk_inv ? (LAST_ADDR - rk_addr) : rk_addr;
`else
    eff_addr = rk_addr;
`endif
    // Range check uses the raw address so reversed reads beyond NR also return 0.
    rd_word = (rk_addr <= LAST_ADDR) ? tbl[eff_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc          <= '0;
      work_key    <= '0;
      rk_data     <= '0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) tbl[i] <= '0;
    end else begin
      rk_data <= rd_word;
      done    <= 1'b0;
      if (clear) begin
        rc          <= '0;
        table_valid <= 1'b0;
        for (int unsigned i = 0; i <= NR; i++) tbl[i] <= '0;
      end else if (accept) begin
        tbl[0]      <= key_in;
        work_key    <= key_in;
        rc          <= RC_W'(1);
        table_valid <= 1'b0;
      end else if (state == EXPAND) begin
        tbl[rc]  <= next_key;
        work_key <= next_key;
        if (rc == RC_LAST) begin
          done        <= 1'b1;
          table_valid <= 1'b1;
        end else begin
          rc <= rc + RC_W'(1);
        end
      end
    end
  end

endmodule
